// File: rtl/rd_skew_ctrl.sv
// Skewed read-address generator: lane i reads num_rows words from base_addr, i cycles after lane 0.
// Optional RD_SKEW_STRIDE_EN adds a latched per-start address stride (default build: stride 1).
module rd_skew_ctrl #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [LEN_W-1:0]          num_rows,
`ifdef RD_SKEW_STRIDE_EN
  input  logic [ADDR_W-1:0]         stride,
`endif
  input  logic                      stall,
  output logic [LANES-1:0]          rd_en,
  output logic [LANES*ADDR_W-1:0]   rd_addr,
  output logic                      busy,
  output logic                      done
);

  localparam int CNT_W = LEN_W + $clog2(LANES) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t              state;
  logic [CNT_W-1:0]    phase;
  logic [CNT_W-1:0]    last_phase;
  logic [LEN_W-1:0]    n_q;
  logic [ADDR_W-1:0]   base_q;

  logic [CNT_W-1:0]         phase_nx;
  logic [LEN_W-1:0]         n_eff;
  logic [ADDR_W-1:0]        base_eff;
  logic [ADDR_W-1:0]        stride_eff;
  logic [CNT_W-1:0]         last_nx;
  logic [LANES-1:0]         en_nx;
  logic [LANES*ADDR_W-1:0]  addr_nx;

`ifdef RD_SKEW_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;
  assign stride_eff = (state == IDLE) ? stride : stride_q;
`else
  assign stride_eff = ADDR_W'(1);
`endif

  // In IDLE the next cycle is phase 0 of a fresh request, so use the live inputs.
  assign phase_nx = (state == IDLE) ? '0 : phase + CNT_W'(1);
  assign n_eff    = (state == IDLE) ? num_rows : n_q;
  assign base_eff = (state == IDLE) ? base_addr : base_q;
  // A zero-length request still spends one busy cycle (phase 0, no enables) before FIN.
  assign last_nx  = (num_rows == '0) ? '0
                  : CNT_W'(num_rows) + CNT_W'(LANES) - CNT_W'(2);

  // A lane that was enabled last cycle steps by the stride; a newly enabled lane starts at base.
  always_comb begin
    en_nx   = '0;
    addr_nx = rd_addr;
    for (int i = 0; i < LANES; i++) begin
      en_nx[i] = (phase_nx >= CNT_W'(i)) && (phase_nx < CNT_W'(i) + CNT_W'(n_eff));
      if (en_nx[i]) begin
        addr_nx[i*ADDR_W +: ADDR_W] = rd_en[i] ? rd_addr[i*ADDR_W +: ADDR_W] + stride_eff
                                               : base_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      phase      <= '0;
      last_phase <= '0;
      n_q        <= '0;
      base_q     <= '0;
`ifdef RD_SKEW_STRIDE_EN
      stride_q   <= '0;
`endif
      rd_en      <= '0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_q        <= num_rows;
            base_q     <= base_addr;
`ifdef RD_SKEW_STRIDE_EN
            stride_q   <= stride;
`endif
            last_phase <= last_nx;
            phase      <= '0;
            rd_en      <= en_nx;
            rd_addr    <= addr_nx;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (!stall) begin
            if (phase == last_phase) begin
              rd_en <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              phase   <= phase_nx;
              rd_en   <= en_nx;
              rd_addr <= addr_nx;
            end
          end
        end
        FIN: begin
          // Leaves unconditionally so a stall can never stretch the done pulse.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          rd_en <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_skew_ctrl.sv
// Bench for rd_skew_ctrl: directed steps plus a few random runs, checked cycle by cycle via an expected queue.
module tb_rd_skew_ctrl;

  localparam int LANES  = 4;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 8;
  localparam int EW     = 2 + LANES + LANES*ADDR_W;

  logic                     clk;
  logic                     reset;
  logic                     start;
  logic [ADDR_W-1:0]        base_addr;
  logic [LEN_W-1:0]         num_rows;
  logic [ADDR_W-1:0]        stride;
  logic                     stall;
  logic [LANES-1:0]         rd_en;
  logic [LANES*ADDR_W-1:0]  rd_addr;
  logic                     busy;
  logic                     done;

  rd_skew_ctrl #(.LANES(LANES), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
`ifdef RD_SKEW_STRIDE_EN
    .stride    (stride),
`endif
    .stall     (stall),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .done      (done)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_cmp;
  int n_fail;

  // reference model: phase 0 idle, 1 active, 2 done cycle
  int                m_phase;
  int                m_t;
  int                m_last_t;
  int                m_n;
  logic [ADDR_W-1:0] m_base;
  logic [ADDR_W-1:0] m_stride;
  logic [ADDR_W-1:0] m_addr[LANES];

  task automatic push_expect();
    logic [LANES-1:0]        en;
    logic [LANES*ADDR_W-1:0] a;
    en = '0;
    a  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (m_phase == 1 && i <= m_t - 1 && m_t - 1 < i + m_n) begin
        en[i]     = 1'b1;
        m_addr[i] = m_base + ADDR_W'((m_t - 1 - i) * int'(m_stride));
      end
      a[i*ADDR_W +: ADDR_W] = m_addr[i];
    end
    exp_q.push_back({(m_phase == 2), (m_phase == 1), en, a});
  endtask

  task automatic check(input string tag);
    logic [EW-1:0] obs;
    logic [EW-1:0] exp;
    obs = {done, busy, rd_en, rd_addr};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) m_addr[i] = '0;
    m_phase = 0;
  endtask

  // Called at a negedge with the DUT idle. stall_len=0 disables stall; extra_edge<0 disables the
  // ignored start pulse; abort_after>0 pulls reset after that many observed cycles.
  task automatic run_seq(input string tag, input logic [ADDR_W-1:0] base_v, input int n_v,
                         input logic [ADDR_W-1:0] stride_v, input int stall_edge,
                         input int stall_len, input int extra_edge, input int abort_after);
    int  e;
    int  obs_cnt;
    bit  st;
    bit  finished;
    start     = 1'b1;
    base_addr = base_v;
    num_rows  = LEN_W'(n_v);
    stride    = stride_v;
    stall     = (stall_len > 0 && stall_edge == 0);
    m_phase   = 1;
    m_t       = 1;
    m_n       = n_v;
    m_base    = base_v;
`ifdef RD_SKEW_STRIDE_EN
    m_stride  = stride_v;
`else
    m_stride  = 1;
`endif
    m_last_t  = (n_v == 0) ? 1 : n_v + LANES - 1;
    e         = 0;
    obs_cnt   = 0;
    finished  = 0;
    for (int k = 0; k < 400 && !finished; k++) begin
      @(posedge clk);
      @(negedge clk);
      push_expect();
      check(tag);
      obs_cnt++;
      if (m_phase == 0) begin
        finished = 1;
      end else if (abort_after > 0 && obs_cnt == abort_after) begin
        start = 1'b0;
        stall = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        push_expect();
        check({tag, "_async_clear"});
        @(posedge clk);
        @(negedge clk);
        push_expect();
        check({tag, "_held_in_reset"});
        reset    = 1'b1;
        finished = 1;
      end else begin
        e++;
        st    = (stall_len > 0 && e >= stall_edge && e < stall_edge + stall_len);
        stall = st;
        start = (e == extra_edge);
        if (start) begin
          base_addr = ADDR_W'($urandom_range(0, 255));
          num_rows  = LEN_W'($urandom_range(1, 255));
          stride    = ADDR_W'($urandom_range(0, 255));
        end
        if (m_phase == 1) begin
          if (!st) begin
            if (m_t == m_last_t) m_phase = 2;
            else m_t++;
          end
        end else begin
          m_phase = 0;
        end
      end
    end
    if (!finished) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: sequence did not return to idle within cycle budget", tag);
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    stride    = '0;
    model_reset();

    @(negedge clk);
    push_expect();
    check("reset_state");
    reset = 1'b1;
    @(negedge clk);
    push_expect();
    check("idle_after_release");

    run_seq("t1_basic",        8'h10, 3,   8'd1, 0, 0, -1, 0);
    run_seq("t2_zero_rows",    8'h55, 0,   8'd1, 0, 0, -1, 0);
    run_seq("t3_wrap",         8'hFE, 4,   8'd1, 0, 0, -1, 0);
    run_seq("t4_stall",        8'h30, 3,   8'd1, 3, 2, -1, 0);
    run_seq("t5_abort",        8'h40, 3,   8'd1, 0, 0, -1, 2);
    @(negedge clk);
    push_expect();
    check("t5_idle_after_abort");
    run_seq("t5_rerun",        8'h40, 3,   8'd1, 0, 0, -1, 0);
    run_seq("t6_start_ignored", 8'h00, 3,  8'd2, 0, 0, 2, 0);
    run_seq("t7_start_with_stall", 8'h70, 2, 8'd1, 0, 3, -1, 0);
    run_seq("t8_single_row",   8'hFF, 1,   8'd3, 0, 0, -1, 0);
    run_seq("t9_max_rows",     8'h80, 255, 8'd1, 100, 3, 50, 0);
    run_seq("t10_stride_zero", 8'h22, 3,   8'd0, 0, 0, -1, 0);

    for (int r = 0; r < 4; r++) begin
      run_seq("rand_seq", ADDR_W'($urandom_range(0, 255)), $urandom_range(1, 8),
              ADDR_W'($urandom_range(0, 5)), $urandom_range(1, 6), $urandom_range(0, 3),
              $urandom_range(1, 6), 0);
    end

    @(negedge clk);
    push_expect();
    check("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
